// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - round-robin ALU/LSU write-back FIFO driving the register file write port.
// Optional operand forwarding from buffered entries when WB_BYPASS_EN is defined.
module regfile_writeback #(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int DEPTH          = 4,
  localparam int NUM_REGS      = 1 << REG_ADDR_WIDTH,
  localparam int CW            = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0]     lsu_data,
  input  logic                      wb_hold,
  output logic                      rf_write_en,
  output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0]     rf_write_data,
  output logic [NUM_REGS-1:0]       pending,
  output logic [CW-1:0]             count,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_addr1,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_addr2,
  output logic                      fwd_hit1,
  output logic                      fwd_hit2,
  output logic [DATA_WIDTH-1:0]     fwd_data1,
  output logic [DATA_WIDTH-1:0]     fwd_data2
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [DEPTH-1:0]          entry_valid;
  logic [REG_ADDR_WIDTH-1:0] entry_addr [DEPTH];
  logic [DATA_WIDTH-1:0]     entry_data [DEPTH];
  logic                      last_grant_lsu;

  logic                      grant_alu;
  logic                      grant_lsu;
  logic                      full;
  logic                      alu_fire;
  logic                      lsu_fire;
  logic                      push;
  logic                      pop;
  logic [REG_ADDR_WIDTH-1:0] push_addr;
  logic [DATA_WIDTH-1:0]     push_data;

  // On a tie the source that did not win last time is granted.
  assign grant_alu = alu_valid && (!lsu_valid || last_grant_lsu);
  assign grant_lsu = lsu_valid && !grant_alu;
  assign full      = (count == CW'(DEPTH));
  assign alu_ready = grant_alu && !full;
  assign lsu_ready = grant_lsu && !full;
  assign alu_fire  = alu_valid && alu_ready;
  assign lsu_fire  = lsu_valid && lsu_ready;
  assign push_addr = alu_fire ? alu_addr : lsu_addr;
  assign push_data = alu_fire ? alu_data : lsu_data;
  // Writes to r0 are acknowledged but never buffered.
  assign push      = (alu_fire || lsu_fire) && (push_addr != '0);
  assign pop       = rf_write_en;

  assign rf_write_en   = (count != '0) && !wb_hold;
  assign rf_write_addr = rf_write_en ? entry_addr[rd_ptr] : '0;
  assign rf_write_data = rf_write_en ? entry_data[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      entry_valid    <= '0;
      last_grant_lsu <= 1'b1;
    end else begin
      if (alu_fire)
        last_grant_lsu <= 1'b0;
      else if (lsu_fire)
        last_grant_lsu <= 1'b1;
      if (push) begin
        entry_valid[wr_ptr] <= 1'b1;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        entry_valid[rd_ptr] <= 1'b0;
        rd_ptr              <= rd_ptr + 1'b1;
      end
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr[wr_ptr] <= push_addr;
      entry_data[wr_ptr] <= push_data;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (entry_valid[i])
        pending = pending | (NUM_REGS'(1) << entry_addr[i]);
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to newest so the newest match overwrites older ones.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[rd_ptr + PW'(i)] && fwd_addr1 != '0 &&
          entry_addr[rd_ptr + PW'(i)] == fwd_addr1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = entry_data[rd_ptr + PW'(i)];
      end
      if (entry_valid[rd_ptr + PW'(i)] && fwd_addr2 != '0 &&
          entry_addr[rd_ptr + PW'(i)] == fwd_addr2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = entry_data[rd_ptr + PW'(i)];
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_addr1, fwd_addr2};
  assign fwd_hit1   = 1'b0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data1  = '0;
  assign fwd_data2  = '0;
`endif

endmodule
